// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe register pipeline.
package dff_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Occupancy counter width: enough bits to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: a WIDTH-bit data register with its valid bit.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             vld_in,
  output logic [WIDTH-1:0] q,
  output logic             vld_out
);

  // Flush has the same effect as reset; otherwise the stage only moves when enabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q       <= RST_VAL;
      vld_out <= 1'b0;
    end else if (en) begin
      q       <= d;
      vld_out <= vld_in;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with stall, flush, per-stage valid,
// occupancy counter and full/empty flags.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter int               DEPTH        = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL      = '0,
  parameter bit               GATE_INVALID = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          d,
  output logic [WIDTH-1:0]          q,
  output logic                      out_valid,
  output logic [cnt_w(DEPTH)-1:0]   fill_cnt,
  output logic                      full,
  output logic                      empty
);

  localparam int            CW        = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("dff_pipe: WIDTH must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe: DEPTH must be >= 1");
  end

  // chain index i feeds stage i; index DEPTH is the last stage's output.
  logic [WIDTH-1:0] chain_d [DEPTH+1];
  logic [DEPTH:0]   chain_v;

  assign chain_d[0] = (GATE_INVALID && !in_valid) ? RST_VAL : d;
  assign chain_v[0] = in_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .en      (en),
      .d       (chain_d[i]),
      .vld_in  (chain_v[i]),
      .q       (chain_d[i+1]),
      .vld_out (chain_v[i+1])
    );
  end

  assign q         = chain_d[DEPTH];
  assign out_valid = chain_v[DEPTH];

  // One beat in and one out leaves occupancy unchanged, so the count never wraps.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      fill_cnt <= '0;
    end else if (en) begin
      if (in_valid && !out_valid) begin
        fill_cnt <= fill_cnt + CW'(1);
      end else if (!in_valid && out_valid) begin
        fill_cnt <= fill_cnt - CW'(1);
      end
    end
  end

  assign full  = (fill_cnt == DEPTH_CNT);
  assign empty = (fill_cnt == '0);

endmodule

// File: tb/tb_dff_pipe.sv
// Directed checks of the 4-deep pipeline plus a randomised run of a 1-deep,
// ungated instance against a small reference model.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       reset, en, clr, in_valid;
  logic [7:0] d;
  logic [7:0] q;
  logic       out_valid, full, empty;
  logic [2:0] fill_cnt;

  logic       b_reset, b_en, b_clr, b_in_valid;
  logic [7:0] b_d;
  logic [7:0] b_q;
  logic       b_out_valid, b_full, b_empty;
  logic [0:0] b_fill_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00), .GATE_INVALID(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid), .d(d),
    .q(q), .out_valid(out_valid), .fill_cnt(fill_cnt), .full(full), .empty(empty)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00), .GATE_INVALID(1'b0)) dut_d1 (
    .clk(clk), .reset(b_reset), .en(b_en), .clr(b_clr), .in_valid(b_in_valid), .d(b_d),
    .q(b_q), .out_valid(b_out_valid), .fill_cnt(b_fill_cnt), .full(b_full), .empty(b_empty)
  );

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; en = 0; clr = 0; in_valid = 0; d = 8'h00;
    b_reset = 1; b_en = 0; b_clr = 0; b_in_valid = 0; b_d = 8'h00;
    tick();
    tick();
    reset = 0; b_reset = 0;
    tests++; if (q !== 8'h00) begin failed++; $display("[TB] FAIL reset_q: got %h want %h", q, 8'h00); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (fill_cnt !== 3'd0) begin failed++; $display("[TB] FAIL reset_fill_cnt: got %0d want 0", fill_cnt); end
    tests++; if (empty !== 1'b1) begin failed++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
    tests++; if (full !== 1'b0) begin failed++; $display("[TB] FAIL reset_full: got %b want 0", full); end
    tests++; if (b_q !== 8'h00 || b_out_valid !== 1'b0 || b_fill_cnt !== 1'b0) begin
      failed++; $display("[TB] FAIL reset_d1: got q=%h v=%b cnt=%0d want 00/0/0", b_q, b_out_valid, b_fill_cnt);
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    en = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      d = vals[i];
      tick();
      tests++; if (fill_cnt !== 3'(i + 1)) begin failed++; $display("[TB] FAIL fill_cnt_%0d: got %0d want %0d", i, fill_cnt, i + 1); end
    end
    tests++; if (q !== 8'hA1) begin failed++; $display("[TB] FAIL fill_q: got %h want a1", q); end
    tests++; if (out_valid !== 1'b1) begin failed++; $display("[TB] FAIL fill_out_valid: got %b want 1", out_valid); end
    tests++; if (full !== 1'b1 || empty !== 1'b0) begin failed++; $display("[TB] FAIL fill_flags: got full=%b empty=%b want 1/0", full, empty); end
    d = 8'hA5;
    tick();
    tests++; if (q !== 8'hA2) begin failed++; $display("[TB] FAIL fill_next_q: got %h want a2", q); end
    tests++; if (fill_cnt !== 3'd4) begin failed++; $display("[TB] FAIL fill_next_cnt: got %0d want 4", fill_cnt); end
  endtask

  task automatic test_stall();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      d = (i[0]) ? 8'h3C : 8'hC3;
      in_valid = i[0];
      tick();
      tests++; if (q !== 8'hA2 || out_valid !== 1'b1 || fill_cnt !== 3'd4) begin
        failed++; $display("[TB] FAIL stall_hold_%0d: got q=%h v=%b cnt=%0d want a2/1/4", i, q, out_valid, fill_cnt);
      end
    end
    en = 1; in_valid = 1;
    d = 8'hA6;
    tick();
    tests++; if (q !== 8'hA3) begin failed++; $display("[TB] FAIL stall_resume_q0: got %h want a3", q); end
    d = 8'hA7;
    tick();
    tests++; if (q !== 8'hA4 || fill_cnt !== 3'd4) begin failed++; $display("[TB] FAIL stall_resume_q1: got q=%h cnt=%0d want a4/4", q, fill_cnt); end
  endtask

  task automatic test_drain();
    logic [7:0] exp_q [4] = '{8'hA5, 8'hA6, 8'hA7, 8'h00};
    en = 1; in_valid = 0; d = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (q !== exp_q[i]) begin failed++; $display("[TB] FAIL drain_q_%0d: got %h want %h", i, q, exp_q[i]); end
      tests++; if (fill_cnt !== 3'(3 - i)) begin failed++; $display("[TB] FAIL drain_cnt_%0d: got %0d want %0d", i, fill_cnt, 3 - i); end
    end
    tests++; if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      failed++; $display("[TB] FAIL drain_flags: got v=%b empty=%b full=%b want 0/1/0", out_valid, empty, full);
    end
  endtask

  task automatic test_flush(input logic with_reset);
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    en = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      d = vals[i];
      tick();
    end
    tests++; if (fill_cnt !== 3'd3) begin failed++; $display("[TB] FAIL flush_pre_cnt_r%0b: got %0d want 3", with_reset, fill_cnt); end
    clr = 1; reset = with_reset; d = 8'h55;
    tick();
    clr = 0; reset = 0;
    tests++; if (fill_cnt !== 3'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      failed++; $display("[TB] FAIL flush_state_r%0b: got cnt=%0d v=%b empty=%b want 0/0/1", with_reset, fill_cnt, out_valid, empty);
    end
    // Push one beat, then bubbles: only that beat may surface, never 8'h55.
    d = 8'h77;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 0; d = 8'h00;
      if (i < 3) begin
        tests++; if (q !== 8'h00 || out_valid !== 1'b0) begin
          failed++; $display("[TB] FAIL flush_drop_r%0b_%0d: got q=%h v=%b want 00/0", with_reset, i, q, out_valid);
        end
      end
    end
    tests++; if (q !== 8'h77 || out_valid !== 1'b1 || fill_cnt !== 3'd1) begin
      failed++; $display("[TB] FAIL flush_resume_r%0b: got q=%h v=%b cnt=%0d want 77/1/1", with_reset, q, out_valid, fill_cnt);
    end
    en = 0;
  endtask

  task automatic test_depth1_random();
    logic [7:0] mq = 8'h00;
    logic       mv = 1'b0;
    int         errs = 0;
    for (int i = 0; i < 1000; i++) begin
      b_en       = 1'($urandom_range(0, 1));
      b_in_valid = 1'($urandom_range(0, 1));
      b_d        = 8'($urandom);
      tick();
      if (b_en) begin
        mq = b_d;
        mv = b_in_valid;
      end
      tests++; if (b_q !== mq) begin failed++; errs++; if (errs < 20) $display("[TB] FAIL d1_q_%0d: got %h want %h", i, b_q, mq); end
      tests++; if (b_out_valid !== mv) begin failed++; errs++; if (errs < 20) $display("[TB] FAIL d1_valid_%0d: got %b want %b", i, b_out_valid, mv); end
      tests++; if (b_fill_cnt !== mv) begin failed++; errs++; if (errs < 20) $display("[TB] FAIL d1_cnt_%0d: got %0d want %0d", i, b_fill_cnt, mv); end
    end
    b_en = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_drain();
    test_flush(1'b0);
    test_flush(1'b1);
    test_depth1_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
